// File: rtl/aurora_link_recovery_pkg.sv
// Shared definitions for the Aurora link recovery sequencer.
//   state_t      : recovery FSM states
//   timer_width  : width of the shared cycle timer ($clog2 of the largest
//                  cycle count, minimum 1)
//   retry_width  : width of retry_cnt ($clog2(max_retries+1), minimum 1)
package aurora_recovery_pkg;

    typedef enum logic [2:0] {
        S_GT_RST,
        S_CORE_RST,
        S_WAIT_UP,
        S_LINKED,
        S_FAILED
    } state_t;

    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int retry_width(input int max_retries);
        return (max_retries + 1 < 2) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/aurora_link_recovery.sv
// Aurora link recovery sequencer.
// Responds to the latched bad-channel flag from the channel monitor by
// sequencing a transceiver reset, then a core reset, then waiting for
// channel_up with a timeout. Timed-out attempts are retried up to
// MAX_RETRIES times before the link is declared failed.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bad_channel    : latched fault flag from the channel monitor
//   channel_up     : Aurora channel_up, synchronous to clk
//   force_reset    : one-cycle restart request, honoured in any state
//   gt_reset       : transceiver reset (active high)
//   aurora_reset   : Aurora core reset (active high)
//   det_clear      : clears the channel monitor latch (active high)
//   link_ok        : channel established and healthy
//   link_failed    : retry budget exhausted
//   retry_cnt      : timed-out attempts since the last link_ok
//   recover_count  : bad_channel recoveries from the linked state
//
// Build option: define AURORA_RECOVERY_STATS_EN to build the 16-bit
// saturating recover_count; otherwise recover_count is tied to zero.
module aurora_link_recovery
    import aurora_recovery_pkg::*;
#(
    parameter int GT_RST_CYCLES   = 256,
    parameter int CORE_RST_CYCLES = 64,
    parameter int UP_TIMEOUT      = 1048576,
    parameter int MAX_RETRIES     = 7
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                bad_channel,
    input  logic                                channel_up,
    input  logic                                force_reset,
    output logic                                gt_reset,
    output logic                                aurora_reset,
    output logic                                det_clear,
    output logic                                link_ok,
    output logic                                link_failed,
    output logic [retry_width(MAX_RETRIES)-1:0] retry_cnt,
    output logic [15:0]                         recover_count
);

    localparam int TW = timer_width(GT_RST_CYCLES, CORE_RST_CYCLES, UP_TIMEOUT);
    localparam int RW = retry_width(MAX_RETRIES);

    localparam logic [TW-1:0] GT_LAST   = TW'(GT_RST_CYCLES - 1);
    localparam logic [TW-1:0] CORE_LAST = TW'(CORE_RST_CYCLES - 1);
    localparam logic [TW-1:0] UP_LAST   = TW'(UP_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry_nxt;
    logic          enter;        // a state is (re)entered at this edge: clear the timer
    logic          bad_recover;  // linked -> reset transition caused by bad_channel

    always_comb begin
        state_nxt   = state;
        retry_nxt   = retry_cnt;
        enter       = 1'b0;
        bad_recover = 1'b0;
        if (force_reset) begin
            // Overrides every other transition, including a recovery in S_LINKED.
            state_nxt = S_GT_RST;
            retry_nxt = '0;
            enter     = 1'b1;
        end else begin
            case (state)
                S_GT_RST: begin
                    if (timer == GT_LAST) begin
                        state_nxt = S_CORE_RST;
                        enter     = 1'b1;
                    end
                end
                S_CORE_RST: begin
                    if (timer == CORE_LAST) begin
                        state_nxt = S_WAIT_UP;
                        enter     = 1'b1;
                    end
                end
                S_WAIT_UP: begin
                    // channel_up is tested first so it wins on the timeout cycle.
                    if (channel_up) begin
                        state_nxt = S_LINKED;
                        retry_nxt = '0;
                        enter     = 1'b1;
                    end else if (timer == UP_LAST) begin
                        enter = 1'b1;
                        if (retry_cnt == RETRY_MAX) begin
                            state_nxt = S_FAILED;
                        end else begin
                            state_nxt = S_GT_RST;
                            retry_nxt = retry_cnt + RW'(1);
                        end
                    end
                end
                S_LINKED: begin
                    // A bare channel_up drop is ignored; the monitor flags it a cycle later.
                    if (bad_channel) begin
                        state_nxt   = S_GT_RST;
                        enter       = 1'b1;
                        bad_recover = 1'b1;
                    end
                end
                S_FAILED: begin
                end
                default: begin
                    state_nxt = S_GT_RST;
                    enter     = 1'b1;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they appear with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_GT_RST;
            timer        <= '0;
            retry_cnt    <= '0;
            gt_reset     <= 1'b1;
            aurora_reset <= 1'b1;
            det_clear    <= 1'b1;
            link_ok      <= 1'b0;
            link_failed  <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= enter ? '0 : timer + TW'(1);
            retry_cnt    <= retry_nxt;
            gt_reset     <= (state_nxt == S_GT_RST);
            aurora_reset <= (state_nxt == S_GT_RST) || (state_nxt == S_CORE_RST) ||
                            (state_nxt == S_FAILED);
            det_clear    <= (state_nxt == S_GT_RST) || (state_nxt == S_CORE_RST) ||
                            (state_nxt == S_FAILED);
            link_ok      <= (state_nxt == S_LINKED);
            link_failed  <= (state_nxt == S_FAILED);
        end
    end

`ifdef AURORA_RECOVERY_STATS_EN
    logic [15:0] recover_cnt;

    // Saturates at 0xFFFF; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recover_cnt <= 16'h0000;
        end else if (bad_recover && (recover_cnt != 16'hFFFF)) begin
            recover_cnt <= recover_cnt + 16'h0001;
        end
    end

    assign recover_count = recover_cnt;
`else
    logic unused_recover;

    assign unused_recover = bad_recover;
    assign recover_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_aurora_link_recovery.sv
// Testbench for aurora_link_recovery: a countdown-based reference model
// pushes the expected output vector each cycle, and the vector is popped
// and compared against the DUT one time unit after the clock edge.
module tb_aurora_link_recovery;
    import aurora_recovery_pkg::*;

    localparam int GT   = 4;
    localparam int CORE = 3;
    localparam int UPT  = 20;
    localparam int MAXR = 2;

`ifdef AURORA_RECOVERY_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int M_GT = 0, M_CORE = 1, M_WAIT = 2, M_LINK = 3, M_FAIL = 4;

    typedef logic [22:0] vec_t;  // gt,aur,det,ok,failed, retry[1:0], recover[15:0]

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bad_channel;
    logic        channel_up;
    logic        force_reset;
    logic        gt_reset;
    logic        aurora_reset;
    logic        det_clear;
    logic        link_ok;
    logic        link_failed;
    logic [1:0]  retry_cnt;
    logic [15:0] recover_count;

    always #5 clk = ~clk;

    aurora_link_recovery #(
        .GT_RST_CYCLES  (GT),
        .CORE_RST_CYCLES(CORE),
        .UP_TIMEOUT     (UPT),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bad_channel  (bad_channel),
        .channel_up   (channel_up),
        .force_reset  (force_reset),
        .gt_reset     (gt_reset),
        .aurora_reset (aurora_reset),
        .det_clear    (det_clear),
        .link_ok      (link_ok),
        .link_failed  (link_failed),
        .retry_cnt    (retry_cnt),
        .recover_count(recover_count)
    );

    int    n_vec = 0;
    int    n_err = 0;
    vec_t  exp_q[$];
    string tag_q[$];

    int m_st;
    int m_left;
    int m_retry;
    int m_rec;

    task automatic chk(input string tag, input vec_t got, input vec_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic vec_t dut_out();
        return {gt_reset, aurora_reset, det_clear, link_ok, link_failed, retry_cnt, recover_count};
    endfunction

    function automatic vec_t model_out();
        logic rs;
        rs = (m_st == M_GT) || (m_st == M_CORE) || (m_st == M_FAIL);
        return {(m_st == M_GT), rs, rs, (m_st == M_LINK), (m_st == M_FAIL),
                2'(m_retry), 16'(m_rec)};
    endfunction

    task automatic model_reset();
        m_st = M_GT; m_left = GT; m_retry = 0; m_rec = 0;
    endtask

    // m_left is the number of edges still to be spent in the current timed state.
    task automatic model_step(input bit bad, input bit up, input bit frc);
        if (frc) begin
            m_st = M_GT; m_left = GT; m_retry = 0;
        end else begin
            case (m_st)
                M_GT:   if (m_left == 1) begin m_st = M_CORE; m_left = CORE; end else m_left--;
                M_CORE: if (m_left == 1) begin m_st = M_WAIT; m_left = UPT; end else m_left--;
                M_WAIT: begin
                    if (up) begin
                        m_st = M_LINK; m_retry = 0;
                    end else if (m_left == 1) begin
                        if (m_retry == MAXR) m_st = M_FAIL;
                        else begin m_retry++; m_st = M_GT; m_left = GT; end
                    end else m_left--;
                end
                M_LINK: if (bad) begin
                    m_st = M_GT; m_left = GT;
                    if (STATS && m_rec < 65535) m_rec++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input string tag, input bit bad, input bit up, input bit frc);
        bad_channel = bad;
        channel_up  = up;
        force_reset = frc;
        model_step(bad, up, frc);
        exp_q.push_back(model_out());
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        chk(tag_q.pop_front(), dut_out(), exp_q.pop_front());
    endtask

    // Run with channel_up held until the model reaches the given state.
    task automatic run_until(input string tag, input int st, input bit up);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_st == st) hit = 1'b1;
            else cycle(tag, 1'b0, up, 1'b0);
        end
        chk({tag, "_bound"}, vec_t'(hit), vec_t'(1));
    endtask

    initial begin
        int  gtc;
        int  corec;
        bit  u;
        bit  hit;

        rst_n = 1'b0; bad_channel = 1'b0; channel_up = 1'b0; force_reset = 1'b0;
        model_reset();
        #12;
        chk("reset", dut_out(), {5'b11100, 2'b00, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;

        // Startup: channel_up raised on the 10th cycle after release.
        gtc   = int'(gt_reset);
        corec = 0;
        for (int i = 0; i < 14; i++) begin
            cycle("startup", 1'b0, (i >= 9), 1'b0);
            if (gt_reset) gtc++;
            if (aurora_reset && !gt_reset) corec++;
        end
        chk("startup_gt_cycles", vec_t'(gtc), vec_t'(GT));
        chk("startup_core_cycles", vec_t'(corec), vec_t'(CORE));
        chk("startup_linked", vec_t'({link_ok, retry_cnt}), vec_t'(3'b100));

        // Fault recovery: bad_channel pulse while linked, then channel_up returns.
        cycle("fault", 1'b1, 1'b1, 1'b0);
        chk("fault_rec", vec_t'(recover_count), vec_t'(STATS ? 1 : 0));
        for (int i = 0; i < 10; i++) cycle("fault_relink", 1'b0, (i >= 7), 1'b0);
        chk("fault_linked", vec_t'(link_ok), vec_t'(1));

        // Exhaustion: no channel_up through all attempts, then force_reset.
        cycle("exh_enter", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3 * (GT + CORE + UPT) + 6; i++) cycle("exhaust", 1'b0, 1'b0, 1'b0);
        chk("exh_failed", vec_t'({link_failed, aurora_reset, retry_cnt}), vec_t'(4'b1110));
        cycle("exh_force", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle("exh_restart", 1'b0, 1'b0, 1'b0);

        // channel_up on the last cycle of a wait window, after one timeout.
        run_until("to_wait", M_WAIT, 1'b0);
        for (int i = 0; i < UPT; i++) cycle("timeout1", 1'b0, 1'b0, 1'b0);
        run_until("to_wait2", M_WAIT, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            u = (m_st == M_WAIT) && (m_left == 1);
            cycle("simul_up", 1'b0, u, 1'b0);
            hit = u;
        end
        chk("simul_linked", vec_t'({hit, link_ok, retry_cnt}), vec_t'(4'b1100));

        // force_reset together with bad_channel: not counted as a recovery.
        cycle("force_bad", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle("relink", 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of the core reset phase.
        cycle("leave_link", 1'b1, 1'b0, 1'b0);
        run_until("to_core", M_CORE, 1'b0);
        cycle("in_core", 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", dut_out(), {5'b11100, 2'b00, 16'h0000});
        model_reset();
        #1;
        rst_n = 1'b1;
        gtc = int'(gt_reset);
        for (int i = 0; i < 12; i++) begin
            cycle("post_reset", 1'b0, 1'b1, 1'b0);
            if (gt_reset) gtc++;
        end
        chk("post_reset_gt_cycles", vec_t'(gtc), vec_t'(GT));

`ifdef AURORA_RECOVERY_STATS_EN
        // Saturation: preload the counter just below its ceiling.
        force dut.recover_cnt = 16'hFFFE;
        #1;
        release dut.recover_cnt;
        m_rec = 65534;
        for (int k = 0; k < 3; k++) begin
            cycle("sat_fault", 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 10; i++) cycle("sat_relink", 1'b0, 1'b1, 1'b0);
        end
        chk("sat_value", vec_t'(recover_count), vec_t'(16'hFFFF));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
